serial_adder_nbits: RTL and testbench
=====================================

# serial_adder_nbits

Bit-serial N-bit two's-complement adder with status flags: the addition counterpart to the team's ripple subtractor, trading area for latency by reusing one full-adder cell over N clock cycles. It accepts an operand pair on a start pulse and shifts the sum out LSB-first into a result register. It reports result, negative, zero, carry and overflow flags with a one-cycle done pulse. It sits in the lab ALU datapath wherever a multi-cycle add is acceptable.

## Interface
- N, default 4: operand/result width in bits; N ≥ 1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  N  operand A, captured when start is accepted.
- b  in  N  operand B, captured when start is accepted.
- op_sub  in  1  present only with ALU_SERIAL_SUB_EN; 1 = compute a − b; captured with operands.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; result/flags valid from this cycle.
- result  out  N  sum, held until next accepted start.
- neg_flag  out  1  result[N-1].
- zr_flag  out  1  result == 0.
- cry_flag  out  1  carry out of bit N-1.
- of_flag  out  1  signed overflow: 1 when a[N-1]==b_eff[N-1] and result[N-1]!=a[N-1].

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 → load shift_a←a, shift_b←b, carry←0, cnt←0, result reg←0; go SHIFT. start=0 → stay.
- SHIFT: full_adder(shift_a[0], shift_b[0], carry) → sum bit shifted into result MSB (result ← {s, result[N-1:1]}); carry←cout; shift_a, shift_b shift right; cnt++. After the Nth bit (cnt==N-1) → DONE.
- DONE: done=1; flags computed from the final result, final carry and the captured operand MSBs; registered. Next cycle → IDLE.
- start in SHIFT or DONE ignored; no queuing.
- Outputs result and flags change only on entry to DONE; they hold through IDLE until the next operation's DONE. Intermediate shifting uses an internal register, not the result port.
- b_eff = b (add) or ~b (subtract).
- Width: counter width $clog2(N)+1; no width growth, carry out reported only via cry_flag.

## Timing
- Reset values: busy=0, done=0, result=0, neg/zr/cry/of flags all 0 (zr_flag is 0 at reset by decision). State is IDLE.
- Latency: start accepted at edge k → done high in cycle k+N+1; result/flags valid in that same cycle.
- Throughput: one operation per N+2 cycles; earliest next accept is the cycle after done.
- rst mid-operation: abort. All outputs return to reset values at the next edge, and no done pulse is issued.
- rst and start in the same cycle: rst wins.
- N=1: a single SHIFT cycle; flags are still defined as above.

## Configuration
- ALU_SERIAL_SUB_EN defined: op_sub port exists. When op_sub=1, b is captured inverted and carry initialises to 1, giving a − b. cry_flag=1 then means no borrow, and of_flag uses b_eff.
- Undefined: no op_sub port; add only, carry initialises to 0.

## Structure
- Package alu_pkg: state_t enum (IDLE, SHIFT, DONE) and a flag-struct typedef {neg, zr, cry, of}. Shared with other ALU blocks.
- One sub-module, full_adder (a, b, cin, s, cout), instantiated once.

## Test plan
- N=4, a=3, b=4, start at cycle 0 → done at cycle 5, result=7, all flags 0.
- a=7, b=1 → result=8, neg=1, of=1, cry=0, zr=0.
- a=15, b=1 → result=0, zr=1, cry=1, of=0, neg=0. Then a=8, b=8 → result=0, zr=1, cry=1, of=1.
- Start with a=2, b=2; assert start again at cycle 2 with a=5 → ignored, result=4. Separately, rst at cycle 2 → outputs all 0, no done, IDLE.
- With ALU_SERIAL_SUB_EN: a=3, b=5, op_sub=1 → result=14, neg=1, cry=0, of=0. a=5, b=3 → result=2, cry=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: FSM state encoding and the status-flag bundle,
// plus the flag derivation common to the add/subtract blocks.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic neg;
      logic zr;
      logic cry;
      logic of;
   } flags_t;

   // Overflow: operands agree in sign but the result sign differs.
   function automatic flags_t make_flags(
      input logic res_msb,
      input logic res_zero,
      input logic cout,
      input logic a_msb,
      input logic b_msb
   );
      flags_t f;
      f.neg = res_msb;
      f.zr  = res_zero;
      f.cry = cout;
      f.of  = (a_msb == b_msb) && (res_msb != a_msb);
      return f;
   endfunction

endpackage

// File: rtl/serial_adder_nbits_full_adder.sv
// Single-bit full adder cell reused every cycle by serial_adder_nbits.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_nbits.sv
// Bit-serial N-bit adder with neg/zero/carry/overflow flags, one bit per cycle.
// Define ALU_SERIAL_SUB_EN to add the op_sub port (a - b via inverted b, carry-in 1).
module serial_adder_nbits
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
`ifdef ALU_SERIAL_SUB_EN
   input  logic         op_sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         neg_flag,
   output logic         zr_flag,
   output logic         cry_flag,
   output logic         of_flag
);

   localparam int             CW       = $clog2(N) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

   state_t         state_q, state_d;
   logic [N-1:0]   shift_a_q, shift_a_d;
   logic [N-1:0]   shift_b_q, shift_b_d;
   logic [N-1:0]   acc_q, acc_d;
   logic           carry_q, carry_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   result_q, result_d;
   flags_t         flags_q, flags_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic           sub_s;
   logic           fa_s, fa_cout;

`ifdef ALU_SERIAL_SUB_EN
   assign sub_s = op_sub;
`else
   assign sub_s = 1'b0;
`endif

   full_adder u_fa (
      .a    (shift_a_q[0]),
      .b    (shift_b_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_a_q <= '0;
         shift_b_q <= '0;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         result_q  <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
         acc_q     <= acc_d;
         carry_q   <= carry_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values; outputs only move on entry to DONE.
   always_comb begin
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      flags_d   = flags_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_a_d = a;
               shift_b_d = sub_s ? ~b : b;
               carry_d   = sub_s;
               cnt_d     = '0;
               acc_d     = '0;
            end else begin
               cnt_d     = cnt_q;
            end
         end
         SHIFT: begin
            acc_d        = acc_q >> 1;
            acc_d[N-1]   = fa_s;
            carry_d      = fa_cout;
            shift_a_d    = shift_a_q >> 1;
            shift_b_d    = shift_b_q >> 1;
            cnt_d        = cnt_q + CW'(1);
            // On the MSB step the adder inputs are the operand sign bits.
            if (cnt_q == CNT_LAST) begin
               result_d = acc_d;
               flags_d  = make_flags(fa_s, (acc_d == '0), fa_cout,
                                     shift_a_q[0], shift_b_q[0]);
               done_d   = 1'b1;
            end else begin
               done_d   = 1'b0;
            end
         end
         DONE:    done_d = 1'b0;
         default: done_d = 1'b0;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign neg_flag = flags_q.neg;
   assign zr_flag  = flags_q.zr;
   assign cry_flag = flags_q.cry;
   assign of_flag  = flags_q.of;

endmodule

// File: tb/tb_serial_adder_nbits.sv
// Self-checking bench for serial_adder_nbits (N=4): transaction-level model
// compared every cycle, plus literal expectations from hand-worked cases.
module tb_serial_adder_nbits;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         op_sub = 1'b0;
   logic         busy, done, neg_flag, zr_flag, cry_flag, of_flag;
   logic [N-1:0] result;

   int checks_total = 0;
   int checks_pass  = 0;
   bit chk_en = 1'b0;

   serial_adder_nbits #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
`ifdef ALU_SERIAL_SUB_EN
      .op_sub   (op_sub),
`endif
      .busy     (busy),
      .done     (done),
      .result   (result),
      .neg_flag (neg_flag),
      .zr_flag  (zr_flag),
      .cry_flag (cry_flag),
      .of_flag  (of_flag)
   );

   always #5 clk = ~clk;

   // Reference model: an operation occupies N+1 cycles after acceptance,
   // its arithmetic result appearing when that window's last cycle starts.
   int           m_left = 0;
   logic         exp_busy = 1'b0, exp_done = 1'b0;
   logic [N-1:0] exp_res = '0, m_res_p = '0;
   logic [3:0]   exp_fl = '0, m_fl_p = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0; exp_busy = 1'b0; exp_done = 1'b0; exp_res = '0; exp_fl = '0;
      end else if (m_left == 0) begin
         exp_done = 1'b0;
         if (start) begin
            int av, bv, sv;
            av = int'(a);
            bv = op_sub ? ((1 << N) - 1 - int'(b)) : int'(b);
            sv = av + bv + (op_sub ? 1 : 0);
            m_res_p = N'(sv % (1 << N));
            m_fl_p[3] = (sv >> (N - 1)) % 2 == 1;
            m_fl_p[2] = (sv % (1 << N)) == 0;
            m_fl_p[1] = sv >= (1 << N);
            m_fl_p[0] = ((av >> (N - 1)) == (bv >> (N - 1))) &&
                        (((sv >> (N - 1)) % 2) != (av >> (N - 1)));
            m_left   = N + 1;
            exp_busy = 1'b1;
         end else begin
            exp_busy = 1'b0;
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 1) begin
            exp_done = 1'b1; exp_res = m_res_p; exp_fl = m_fl_p;
         end else if (m_left == 0) begin
            exp_done = 1'b0; exp_busy = 1'b0;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         checks_total++;
         if ({busy, done, result, neg_flag, zr_flag, cry_flag, of_flag} ===
             {exp_busy, exp_done, exp_res, exp_fl}) begin
            checks_pass++;
         end else begin
            $display("FAIL cycle_cmp t=%0t got busy=%b done=%b res=%h fl=%b%b%b%b exp busy=%b done=%b res=%h fl=%b",
                     $time, busy, done, result, neg_flag, zr_flag, cry_flag, of_flag,
                     exp_busy, exp_done, exp_res, exp_fl);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks_total++;
      if (got === expv) begin
         checks_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", name, got, expv);
      end
   endtask

   // Issue one operation from IDLE, check latency, result and flags {neg,zr,cry,of}.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tsub,
                         input logic [N-1:0] eres, input logic [3:0] efl, input string name);
      int lat;
      bit seen;
      @(posedge clk); #1;
      a = ta; b = tb; op_sub = tsub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; seen = 1'b0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; lat = i; end
      end
      chk({name, "_latency"}, 32'(lat), 32'd5);
      chk({name, "_result"}, 32'(result), 32'(eres));
      chk({name, "_flags"}, {28'd0, neg_flag, zr_flag, cry_flag, of_flag}, {28'd0, efl});
   endtask

   initial begin
      int ndone;
      bit seen;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {22'd0, busy, done, result, neg_flag, zr_flag, cry_flag, of_flag}, 32'd0);

      run_op(4'd3,  4'd4, 1'b0, 4'd7, 4'b0000, "add_3_4");
      run_op(4'd7,  4'd1, 1'b0, 4'd8, 4'b1001, "add_7_1");
      run_op(4'd15, 4'd1, 1'b0, 4'd0, 4'b0110, "add_15_1");
      run_op(4'd8,  4'd8, 1'b0, 4'd0, 4'b0111, "add_8_8");

      // Second start during SHIFT must be ignored.
      @(posedge clk); #1 a = 4'd2; b = 4'd2; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 a = 4'd5; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("ignore_start_done", 32'(seen), 32'd1);
      chk("ignore_start_result", 32'(result), 32'd4);

      // Reset mid-operation: abort, clear outputs, no done.
      @(posedge clk); @(posedge clk); #1 a = 4'd2; b = 4'd2; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_outputs", {22'd0, busy, done, result, neg_flag, zr_flag, cry_flag, of_flag}, 32'd0);
      ndone = 0;
      for (int i = 0; i < N + 3; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);

`ifdef ALU_SERIAL_SUB_EN
      run_op(4'd3, 4'd5, 1'b1, 4'd14, 4'b1000, "sub_3_5");
      run_op(4'd5, 4'd3, 1'b1, 4'd2,  4'b0010, "sub_5_3");
`endif

      // Random traffic, including starts while busy and occasional resets.
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         a     = N'($urandom_range(0, (1 << N) - 1));
         b     = N'($urandom_range(0, (1 << N) - 1));
         start = ($urandom_range(0, 2) != 0);
         rst   = ($urandom_range(0, 59) == 0);
`ifdef ALU_SERIAL_SUB_EN
         op_sub = ($urandom_range(0, 1) == 1);
`else
         op_sub = 1'b0;
`endif
      end
      @(posedge clk); #1 start = 1'b0; rst = 1'b0;
      repeat (N + 4) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end

endmodule
